// File: rtl/ilv_pkg.sv
// Shared constants, FSM state type and CRC-24 step function for the interleaver front end.
package ilv_pkg;

  localparam int          K_SMALL  = 1056;
  localparam int          K_LARGE  = 6144;
  localparam int          CRC_LEN  = 24;
  localparam logic [23:0] POLY_24A = 24'h864CFB;
  localparam logic [23:0] POLY_24B = 24'h800063;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } state_t;

  typedef logic [12:0] count_t;

  // One MSB-first serial step of the CRC register.
  function automatic logic [23:0] crc_step(input logic [23:0] crc,
                                           input logic        d,
                                           input logic [23:0] poly);
    return {crc[22:0], 1'b0} ^ ((crc[23] ^ d) ? poly : 24'h0);
  endfunction

endpackage

// File: rtl/crc24_lfsr.sv
// Serial CRC-24 register: clear-and-fold on the first bit, fold while enabled,
// shift left to stream out the parity MSB-first.
module crc24_lfsr (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_din,
  input  logic i_shift,
  input  logic i_poly_sel,
  output logic o_msb
);
  import ilv_pkg::*;

  logic [23:0] r_crc;
  logic [23:0] w_base;
  logic [23:0] w_poly;

  assign w_base = i_clr ? 24'h0 : r_crc;
  assign w_poly = i_poly_sel ? POLY_24B : POLY_24A;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc <= 24'h0;
    end else if (i_en) begin
      r_crc <= crc_step(w_base, i_din, w_poly);
    end else if (i_shift) begin
      r_crc <= {r_crc[22:0], 1'b0};
    end
  end

  assign o_msb = r_crc[23];

endmodule

// File: rtl/crc24_attach.sv
// Appends LTE CRC-24 parity to a serial payload and emits a gap-free K-bit frame.
// Optional macro CRC24B_SEL_EN adds a crc_sel input that selects CRC-24B per block.
module crc24_attach #(
  parameter int K_SMALL = ilv_pkg::K_SMALL,
  parameter int K_LARGE = ilv_pkg::K_LARGE
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_data,
  input  logic in_sop,
  input  logic blk_sel,
`ifdef CRC24B_SEL_EN
  input  logic crc_sel,
`endif
  output logic in_ready,
  input  logic dn_ready,
  output logic block_size,
  output logic CRC_start,
  output logic CRC_data,
  output logic CRC_END,
  output logic busy,
  output logic underrun_err
);
  import ilv_pkg::state_t;
  import ilv_pkg::count_t;
  import ilv_pkg::CRC_LEN;
  import ilv_pkg::ST_IDLE;
  import ilv_pkg::ST_PAYLOAD;
  import ilv_pkg::ST_PARITY;
  import ilv_pkg::ST_GAP;

  localparam count_t P_SMALL = count_t'(K_SMALL - CRC_LEN);
  localparam count_t P_LARGE = count_t'(K_LARGE - CRC_LEN);
  localparam count_t F_SMALL = count_t'(K_SMALL);
  localparam count_t F_LARGE = count_t'(K_LARGE);

  state_t r_state, w_state_nxt;
  count_t r_count, w_count_inc, w_pay_len, w_frame_len;
  logic   r_blk, r_data, r_start, r_end, r_busy, r_err;
  logic   w_accept, w_pay_bit, w_end, w_lfsr_clr, w_lfsr_en, w_lfsr_shift;
  logic   w_crc_msb, w_poly_sel, w_in_ready;

  assign w_count_inc = r_count + count_t'(1);
  assign w_pay_len   = r_blk ? P_LARGE : P_SMALL;
  assign w_frame_len = r_blk ? F_LARGE : F_SMALL;
  // Missing input beats become filler zeros so the frame never stalls.
  assign w_pay_bit   = in_valid & in_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    w_end        = 1'b0;
    w_lfsr_clr   = 1'b0;
    w_lfsr_en    = 1'b0;
    w_lfsr_shift = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = dn_ready;
        if (in_valid && in_sop && dn_ready) begin
          w_accept    = 1'b1;
          w_lfsr_clr  = 1'b1;
          w_lfsr_en   = 1'b1;
          w_state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        w_in_ready = 1'b1;
        w_lfsr_en  = 1'b1;
        if (w_count_inc == w_pay_len) w_state_nxt = ST_PARITY;
      end
      ST_PARITY: begin
        w_lfsr_shift = 1'b1;
        if (w_count_inc == w_frame_len) begin
          w_end       = 1'b1;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_data  <= 1'b0;
      r_start <= 1'b0;
      r_end   <= 1'b0;
      r_blk   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_start <= w_accept;
      r_end   <= w_end;
      r_data  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data  <= w_pay_bit;
            r_count <= count_t'(1);
            r_blk   <= blk_sel;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        ST_PAYLOAD: begin
          r_data  <= w_pay_bit;
          r_count <= w_count_inc;
          if (!in_valid) r_err <= 1'b1;
        end
        ST_PARITY: begin
          r_data  <= w_crc_msb;
          r_count <= w_count_inc;
        end
        ST_GAP: begin
          r_count <= '0;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CRC24B_SEL_EN
  logic r_poly_sel;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_poly_sel <= 1'b0;
    else if (w_accept) r_poly_sel <= crc_sel;
  end
  // The SOP bit is folded before the selection is registered.
  assign w_poly_sel = w_accept ? crc_sel : r_poly_sel;
`else
  assign w_poly_sel = 1'b0;
`endif

  crc24_lfsr u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_lfsr_clr),
    .i_en       (w_lfsr_en),
    .i_din      (w_pay_bit),
    .i_shift    (w_lfsr_shift),
    .i_poly_sel (w_poly_sel),
    .o_msb      (w_crc_msb)
  );

  assign in_ready     = w_in_ready;
  assign block_size   = r_blk;
  assign CRC_start    = r_start;
  assign CRC_data     = r_data;
  assign CRC_END      = r_end;
  assign busy         = r_busy;
  assign underrun_err = r_err;

endmodule

// File: tb/tb_crc24_attach.sv
// Bench for crc24_attach: table of frames checked against a polynomial long-division CRC model.
module tb_crc24_attach;

  localparam int KS = 1056;
  localparam int KL = 6144;

  logic clk = 1'b0;
  logic reset, in_valid, in_data, in_sop, blk_sel, in_ready, dn_ready;
  logic block_size, CRC_start, CRC_data, CRC_END, busy, underrun_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_stamp[$];
  logic pay[KL];
  logic cap[KL];

  typedef struct packed {
    logic        blk;
    int          kind;     // 0 zeros, 1 zeros then a final 1, 2 random, 3 ones
    int          ur_at;
    int          ur_len;
    int          dn_wait;
    logic        known;
    logic [23:0] par;
  } vec_t;

  vec_t vt[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (CRC_start) start_stamp.push_back(cyc);

  crc24_attach #(.K_SMALL(KS), .K_LARGE(KL)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_sop       (in_sop),
    .blk_sel      (blk_sel),
    .in_ready     (in_ready),
    .dn_ready     (dn_ready),
    .block_size   (block_size),
    .CRC_start    (CRC_start),
    .CRC_data     (CRC_data),
    .CRC_END      (CRC_END),
    .busy         (busy),
    .underrun_err (underrun_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Remainder of M(x)*x^24 divided by G(x), by long division over the message bits.
  function automatic logic [23:0] crc_ref(input int n);
    logic        wk[KL + 24];
    logic [24:0] g;
    logic [23:0] r;
    g = {1'b1, 24'h864CFB};
    for (int i = 0; i < n; i++) wk[i] = pay[i];
    for (int i = 0; i < 24; i++) wk[n + i] = 1'b0;
    for (int i = 0; i < n; i++)
      if (wk[i]) for (int j = 0; j < 25; j++) wk[i + j] = wk[i + j] ^ g[24 - j];
    for (int k = 0; k < 24; k++) r[23 - k] = wk[n + k];
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input logic prev_err);
    int K, P, t, t_start, t_end, nbit, bad;
    logic [23:0] par_got, par_exp;
    K = v.blk ? KL : KS;
    P = K - 24;
    for (int i = 0; i < P; i++) begin
      case (v.kind)
        0:       pay[i] = 1'b0;
        1:       pay[i] = (i == P - 1);
        2:       pay[i] = 1'($urandom);
        default: pay[i] = 1'b1;
      endcase
    end
    if (v.ur_len > 0) for (int i = v.ur_at; i < v.ur_at + v.ur_len; i++) pay[i] = 1'b0;
    par_exp = v.known ? v.par : crc_ref(P);

    @(negedge clk);
    chk("err_held", 32'(underrun_err), 32'(prev_err));
    chk("idle_data", 32'(CRC_data), 32'd0);
    for (int w = 0; w < v.dn_wait; w++) begin
      dn_ready = 1'b0; in_valid = 1'b1; in_sop = 1'b1; in_data = pay[0]; blk_sel = v.blk;
      #1 chk("ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("no_start", 32'(CRC_start), 32'd0);
    end
    dn_ready = 1'b1; in_valid = 1'b1; in_sop = 1'b1; in_data = pay[0]; blk_sel = v.blk;
    #1 chk("ready_idle", 32'(in_ready), 32'd1);

    t = 0; t_start = -1; t_end = -1; nbit = 0;
    while (t_end < 0 && t < K + 8) begin
      @(negedge clk);
      t++;
      if (CRC_start && t_start < 0) t_start = t;
      if (t_start >= 0 && nbit < K) begin
        cap[nbit] = CRC_data;
        nbit++;
      end
      if (CRC_END) t_end = t;
      if (t == 10) chk("busy_mid", 32'(busy), 32'd1);
      if (t == 5) chk("ready_payload", 32'(in_ready), 32'd1);
      if (t == P + 1) chk("ready_parity", 32'(in_ready), 32'd0);
      dn_ready = !(v.dn_wait > 0 && t >= 100 && t < 150);
      if (t < P) begin
        in_sop = 1'($urandom);
        if (v.ur_len > 0 && t >= v.ur_at && t < v.ur_at + v.ur_len) begin
          in_valid = 1'b0; in_data = 1'b1;
        end else begin
          in_valid = 1'b1; in_data = pay[t];
        end
      end else begin
        in_valid = 1'b0; in_data = 1'b0; in_sop = 1'b0;
      end
    end
    dn_ready = 1'b1;

    chk("start_latency", 32'(t_start), 32'd1);
    chk("frame_len", 32'(t_end - t_start + 1), 32'(K));
    bad = 0;
    for (int i = 0; i < P; i++) if (cap[i] !== pay[i]) bad++;
    chk("payload_bits", 32'(bad), 32'd0);
    for (int k = 0; k < 24; k++) par_got[23 - k] = cap[P + k];
    chk("parity", 32'(par_got), 32'(par_exp));
    chk("block_size", 32'(block_size), 32'(v.blk));
    chk("underrun_err", 32'(underrun_err), 32'(v.ur_len > 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   sz, diff;
    logic pe;
    vec_t rv;

    reset = 1'b1; in_valid = 1'b0; in_data = 1'b0; in_sop = 1'b0; blk_sel = 1'b0; dn_ready = 1'b1;
    #1;
    chk("rst_start", 32'(CRC_start), 32'd0);
    chk("rst_end", 32'(CRC_END), 32'd0);
    chk("rst_data", 32'(CRC_data), 32'd0);
    chk("rst_bsize", 32'(block_size), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(underrun_err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Non-SOP beats while idle are discarded.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_sop = 1'b0; in_data = 1'($urandom);
      @(negedge clk);
      chk("idle_nostart", 32'(CRC_start), 32'd0);
      chk("idle_zero", 32'(CRC_data), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;

    vt[0] = '{blk: 1'b0, kind: 0, ur_at: 0,   ur_len: 0, dn_wait: 0, known: 1'b1, par: 24'h000000};
    vt[1] = '{blk: 1'b1, kind: 1, ur_at: 0,   ur_len: 0, dn_wait: 0, known: 1'b1, par: 24'h864CFB};
    vt[2] = '{blk: 1'b0, kind: 2, ur_at: 0,   ur_len: 0, dn_wait: 0, known: 1'b0, par: 24'h0};
    vt[3] = '{blk: 1'b0, kind: 2, ur_at: 0,   ur_len: 0, dn_wait: 0, known: 1'b0, par: 24'h0};
    vt[4] = '{blk: 1'b0, kind: 2, ur_at: 400, ur_len: 3, dn_wait: 0, known: 1'b0, par: 24'h0};
    vt[5] = '{blk: 1'b0, kind: 3, ur_at: 0,   ur_len: 0, dn_wait: 4, known: 1'b0, par: 24'h0};
    vt[6] = '{blk: 1'b0, kind: 1, ur_at: 0,   ur_len: 0, dn_wait: 0, known: 1'b1, par: 24'h864CFB};

    pe = 1'b0;
    sz = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) sz = start_stamp.size();
      run_vec(vt[i], pe);
      pe = (vt[i].ur_len > 0);
      if (i == 3) begin
        diff = (start_stamp.size() >= sz + 2) ? start_stamp[sz + 1] - start_stamp[sz] : -1;
        chk("b2b_interval", 32'(diff), 32'(KS + 1));
      end
    end

    // Abort a large block at payload bit 500 with an asynchronous reset.
    for (int i = 0; i < KL; i++) pay[i] = 1'($urandom);
    @(negedge clk);
    dn_ready = 1'b1; in_valid = 1'b1; in_sop = 1'b1; blk_sel = 1'b1; in_data = pay[0];
    for (int t = 1; t <= 500; t++) begin
      @(negedge clk);
      in_sop = 1'b0; in_valid = (t != 200); in_data = pay[t];
    end
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_err", 32'(underrun_err), 32'd1);
    chk("pre_rst_bsize", 32'(block_size), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(underrun_err), 32'd0);
    chk("arst_bsize", 32'(block_size), 32'd0);
    chk("arst_start", 32'(CRC_start), 32'd0);
    chk("arst_end", 32'(CRC_END), 32'd0);
    chk("arst_data", 32'(CRC_data), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0; in_sop = 1'b0; blk_sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rv = '{blk: 1'b0, kind: 2, ur_at: 0, ur_len: 0, dn_wait: 0, known: 1'b0, par: 24'h0};
    run_vec(rv, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
